// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - FIFO read engine draining a fixed-length burst onto a valid/ready stream
module fifo_burst_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] burst_len,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] words_read,
  output logic                   read_en,
  input  logic [DATA_WIDTH-1:0]  data_outp,
  input  logic                   fifo_empty,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  input  logic                   m_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  state_t                 state;
  state_t                 state_nxt;
  logic [COUNT_WIDTH-1:0] len;
  logic [COUNT_WIDTH-1:0] issued;
  logic                   inflight;
  logic [1:0]             occ;
  logic                   head;
  logic [DATA_WIDTH-1:0]  mem0;
  logic [DATA_WIDTH-1:0]  mem1;

  logic accept;
  logic pop;
  logic capture;
  logic tail;
  logic room;

  assign accept  = (state == IDLE) && start;
  assign m_valid = (occ != 2'd0);
  assign m_data  = head ? mem1 : mem0;
  assign pop     = m_valid && m_ready;
  assign capture = inflight;
  // With occ==2 the slot being freed by this cycle's pop is the tail.
  assign tail    = head ^ occ[0];
  assign room    = (({1'b0, occ} + {2'b00, inflight}) < 3'd2) || pop;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    read_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (burst_len == '0) ? DONE : READ;
        end
      end
      READ: begin
        read_en = !fifo_empty && (issued < len) && room;
        if (pop && (words_read + ONE == len)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      len        <= '0;
      issued     <= '0;
      words_read <= '0;
      inflight   <= 1'b0;
      occ        <= 2'd0;
      head       <= 1'b0;
      mem0       <= '0;
      mem1       <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= read_en;
      if (accept) begin
        len        <= burst_len;
        issued     <= '0;
        words_read <= '0;
      end else begin
        if (read_en) issued <= issued + ONE;
        if (pop) words_read <= words_read + ONE;
      end
      if (capture && !pop) begin
        occ <= occ + 2'd1;
      end else if (!capture && pop) begin
        occ <= occ - 2'd1;
      end
      if (pop) head <= ~head;
      if (capture) begin
        if (tail) mem1 <= data_outp;
        else      mem0 <= data_outp;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - scoreboard bench for fifo_burst_reader with a behavioural FIFO and stream model
module tb_fifo_burst_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] burst_len = '0;
  logic        busy;
  logic        done;
  logic [15:0] words_read;
  logic        read_en;
  logic [7:0]  data_outp = 8'h00;
  logic        fifo_empty;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready = 1'b0;

  fifo_burst_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .words_read(words_read), .read_en(read_en),
    .data_outp(data_outp), .fifo_empty(fifo_empty), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready)
  );

  always #5 clock = ~clock;

  // Environment FIFO: one-cycle read latency, pointers owned by separate processes.
  logic [7:0] fmem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clock) begin
    if (read_en && !fifo_empty) begin
      data_outp <= fmem[rd_ptr % 4096];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Reference model: words not yet claimed, expected stream, expected burst counts.
  logic [7:0] ref_q [$];
  logic [7:0] exp_q [$];
  int         done_q [$];
  int         owed = 0;
  int         n_checks = 0;
  int         n_fails = 0;
  int         n_done = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = 8'h00;
  bit         stop_mon = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    fmem[wr_ptr % 4096] = w;
    wr_ptr = wr_ptr + 1;
    if (owed > 0) begin
      exp_q.push_back(w);
      owed--;
    end else begin
      ref_q.push_back(w);
    end
  endtask

  task automatic model_start(input int n);
    done_q.push_back(n);
    for (int i = 0; i < n; i++) begin
      if (ref_q.size() > 0) exp_q.push_back(ref_q.pop_front());
      else owed++;
    end
  endtask

  task automatic mon_step();
    if (read_en && fifo_empty) check("read_while_empty", 1, 0);
    if (prev_stall && m_valid) check("stall_hold", m_data, prev_data);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) check("extra_word", 1, 0);
      else check("stream_data", m_data, exp_q.pop_front());
    end
    if (done) begin
      n_done++;
      check("done_busy", busy, 1);
      if (done_q.size() == 0) check("unexpected_done", 1, 0);
      else check("done_words_read", words_read, done_q.pop_front());
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    burst_len = 16'(n);
    model_start(n);
    cyc();
    start = 1'b0;
    burst_len = 16'($urandom);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && k < limit) begin
      cyc();
      k++;
    end
    check("burst_timeout", busy, 0);
  endtask

  task automatic check_drained();
    check("exp_drained", exp_q.size(), 0);
    check("owed_drained", owed, 0);
  endtask

  task automatic stimulus();
    logic [8:1] re_seen;
    logic [8:1] mv_seen;
    logic [8:1] dn_seen;
    logic [7:0] w0;
    int         cnt;
    int         done0;
    int         n;
    int         pre;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom); burst_len = 16'($urandom); m_ready = 1'($urandom);
      cyc();
    end
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read_en", read_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_words_read", words_read, 0);
    cyc();
    start = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (read_en || busy) cnt++;
      cyc();
    end
    check("idle_no_activity", cnt, 0);

    // Full-rate burst of four
    m_ready = 1'b1;
    do_start(4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      re_seen[c] = read_en; mv_seen[c] = m_valid; dn_seen[c] = done;
      if (c >= 3 && c <= 6) check("full_m_data", m_data, 8'hA0 + 8'(c - 3));
      if (c == 7) check("full_words_read", words_read, 4);
      cyc();
    end
    check("full_read_en_cycles", re_seen, 8'b0000_1111);
    check("full_m_valid_cycles", mv_seen, 8'b0011_1100);
    check("full_done_cycle", dn_seen, 8'b0100_0000);
    check_drained();

    // Backpressure: ten stalled cycles
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    w0 = ref_q[0];
    m_ready = 1'b0;
    do_start(8);
    cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (read_en) cnt++;
      if (c >= 3) check("bp_head_word", m_data, w0);
      cyc();
    end
    check("bp_read_pulses", cnt, 2);
    m_ready = 1'b1;
    wait_idle(100);
    check_drained();

    // FIFO runs dry mid-burst
    done0 = n_done;
    push_word(8'($urandom));
    push_word(8'($urandom));
    do_start(5);
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (read_en) cnt++;
      cyc();
    end
    check("empty_read_pulses", cnt, 2);
    check("empty_still_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      push_word(8'($urandom));
      cyc();
    end
    wait_idle(100);
    cyc();
    check("empty_done_once", n_done - done0, 1);
    check_drained();

    // Zero length
    do_start(0);
    @(negedge clock);
    check("zero_done", done, 1);
    check("zero_read_en", read_en, 0);
    check("zero_m_valid", m_valid, 0);
    cyc();
    @(negedge clock);
    check("zero_back_idle", busy, 0);
    cyc();

    // Start pulsed mid-burst with another length
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    do_start(4);
    start = 1'b1; burst_len = 16'd9;
    cyc();
    start = 1'b0;
    wait_idle(100);
    check_drained();

    // Reset while two words sit in the skid buffer
    for (int i = 0; i < 6; i++) push_word(8'($urandom));
    m_ready = 1'b0;
    do_start(6);
    repeat (5) cyc();
    check("pre_reset_valid", m_valid, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_read_en", read_en, 0);
    check("mid_rst_m_data", m_data, 0);
    check("mid_rst_words_read", words_read, 0);
    // Two words left the FIFO and are lost; the rest return to the unclaimed pool.
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    while (exp_q.size() > 0) ref_q.push_front(exp_q.pop_back());
    void'(done_q.pop_back());
    cyc();
    reset = 1'b1;
    m_ready = 1'b1;
    cyc();
    do_start(2);
    wait_idle(100);
    check_drained();

    // Randomized bursts with random backpressure, late pushes and stray starts
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 9);
      pre = $urandom_range(0, n + 2);
      for (int i = 0; i < pre; i++) push_word(8'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      do_start(n);
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b1; burst_len = 16'($urandom_range(0, 20));
      end
      for (int k = 0; k < 400 && busy; k++) begin
        cyc();
        start = 1'b0;
        m_ready = ($urandom_range(0, 3) != 0);
        if (owed > 0 && $urandom_range(0, 2) == 0) push_word(8'($urandom));
      end
      start = 1'b0;
      wait_idle(10);
      cyc();
      check_drained();
    end
  endtask

  initial begin
    fork
      begin
        while (!stop_mon) begin
          @(negedge clock);
          if (!stop_mon) mon_step();
        end
      end
      begin
        stimulus();
        repeat (3) cyc();
        check("done_queue_empty", done_q.size(), 0);
        stop_mon = 1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
